trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Parametrised successor to the write-back exception/CSR logic.
- Owns the machine trap CSRs.
- Prioritises synchronous exceptions against a configurable set of level- or edge-triggered interrupt lines.
- Sequences trap entry and MRET through a small FSM that stalls retirement, flushes the pipe and redirects fetch. It sits beside the write-back stage; write-back asserts retire/exception info and obeys retire_ready_o.

Parameters:
- XLEN, 32, datapath width of all CSRs and PCs.
- NUM_IRQ, 4, platform interrupt lines, 1..16; line i maps to mcause code 16+i.
- EDGE_MASK, {NUM_IRQ{1'b0}}, per-line: 1 = rising-edge latched, 0 = level.
- MTVEC_RST, 32'h0000_0100, reset value of mtvec.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-low reset
- retire_valid_i  in  1  instruction in WB wants to retire
- retire_pc_i  in  XLEN  its PC
- exc_valid_i  in  1  instruction carries a synchronous exception
- exc_cause_i  in  4  exception code (0,2,3,4,6,11)
- exc_tval_i  in  XLEN  trap value
- mret_i  in  1  instruction is MRET
- xint_meip_i / xint_mtip_i / xint_msip_i  in  1 each  standard machine interrupts, level
- irq_i  in  NUM_IRQ  platform interrupts
- csr_we_i  in  1  CSR write strobe from WB
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  final write data, after RW/RS/RC resolved upstream
- csr_rdata_o  out  XLEN  combinational read of csr_addr_i
- csr_illegal_o  out  1  csr_addr_i not implemented
- retire_ready_o  out  1  WB may commit this cycle
- flush_o  out  1  one-cycle pipeline flush
- redirect_valid_o  out  1  one-cycle fetch redirect
- redirect_pc_o  out  XLEN  redirect target

Behaviour:
- Reset (rst_i==0 at posedge):
  - State = IDLE.
  - mstatus.MIE = 0, MPIE = 0, MPP reads 2'b11.
  - mie = 0, mepc = 0, mcause = 0, mtval = 0, mtvec = MTVEC_RST.
  - Edge pend latches = 0, irq_prev = 0.
  - Outputs: retire_ready_o = 1, flush_o = 0, redirect_valid_o = 0, redirect_pc_o = 0.
  - Reset mid-sequence aborts; no partial CSR update survives.
- Implemented CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343, mip 0x344. All other addresses: csr_illegal_o = 1 and reads return 0.
- mip composition:
  - bit11 = meip, bit7 = mtip, bit3 = msip.
  - Bit 16+i = level line i, or edge latch i for edge lines.
  - Software writes to mip may only clear edge latches.
- Edge latch i sets when irq_i[i] & ~irq_prev[i]. A same-cycle set and clear gives set.
- int_pend = mstatus.MIE & |(mip & mie).
- Interrupt priority: 11 > 3 > 7 > 16 > 17 > … (lowest index first).
- FSM states: IDLE, ENTER, RET.
  - IDLE, retire_valid_i & int_pend:
    - Interrupt wins over exc/mret.
    - retire_ready_o = 0 (instruction not committed).
    - Capture: mepc = retire_pc_i, mcause = {1, code}, mtval = 0.
    - Go to ENTER.
  - IDLE, retire_valid_i & exc_valid_i:
    - retire_ready_o = 0.
    - Capture: mepc = retire_pc_i, mcause = {0, exc_cause_i}, mtval = exc_tval_i.
    - Go to ENTER.
  - IDLE, retire_valid_i & mret_i: retire_ready_o = 1, go to RET.
  - ENTER (1 cycle):
    - MPIE = MIE, MIE = 0; clear the edge latch of the taken interrupt.
    - flush_o = redirect_valid_o = 1.
    - redirect_pc_o = mtvec base, or base + 4*code when mtvec[1:0] == 01 and the trap is an interrupt.
    - retire_ready_o = 0. Go to IDLE.
  - RET (1 cycle):
    - MIE = MPIE, MPIE = 1.
    - flush/redirect to mepc.
    - retire_ready_o = 0. Go to IDLE.
- CSR writes:
  - Honoured only in IDLE with retire_ready_o = 1.
  - A trap capture in the same cycle wins; the write is dropped.
  - mepc[1:0] and mtvec[1] are forced to 0.
- Pipeline latency: trap detect -> redirect exactly 1 cycle. The next retire is accepted 2 cycles after detect.

Decomposition:
- Shared package trap_pkg holds:
  - CSR address constants.
  - Cause codes: IAM = 0, II = 2, BP = 3, LAM = 4, SAM = 6, ECALL = 11, MSI = 3, MTI = 7, MEI = 11.
  - mstatus bit indices.
  - FSM state enum.
- One natural sub-module, irq_pend, owns per-line edge/level latching and the priority encoder. It outputs pend_valid, pend_code and the mip vector.

Test Plan:
- Reset with rst_i = 0 for 2 cycles:
  - mtvec reads 0x100, mstatus reads 0x1800.
  - retire_ready_o = 1, no redirect.
- Exception: retire pc 0x2000, exc_valid_i, cause 2, tval 0xDEADBEEF:
  - Next cycle flush_o/redirect_valid_o = 1, redirect_pc_o = 0x100.
  - mepc = 0x2000, mcause = 2, mtval = 0xDEADBEEF.
- Vectored interrupt: mtvec = 0x401, MIE = 1, mie[7] = 1, mtip = 1, retire pc 0x3000:
  - redirect_pc_o = 0x41C, mcause = 0x80000007, MIE = 0, MPIE = 1.
- Priority: meip, mtip and irq_i[0] all raised together with all enabled:
  - mcause = 0x8000000B.
  - Clear meip, MRET: the next trap is cause 0x80000003-less order, i.e. 0x80000007, then 0x80000010.
- Edge line (EDGE_MASK = 1): 1-cycle pulse on irq_i[0] while MIE = 0:
  - mip[16] stays 1.
  - Enable MIE: trap taken, latch cleared in ENTER.
  - CSR write of 0 to mip also clears the latch.
- MRET with mepc = 0x2004, MPIE = 1:
  - redirect_pc_o = 0x2004, MIE = 1.
  - Reset asserted during the RET cycle leaves MIE = 0 and no redirect.

Source files
------------

// File: rtl/trap_pkg.sv
`default_nettype none
// ============================================================================
// Module      : trap_pkg
// Description : Shared constants for the machine trap controller: CSR
//               addresses, cause codes, mstatus bit positions, FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package trap_pkg;

    // Implemented machine CSR addresses
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MTVAL   = 12'h343;
    localparam logic [11:0] CSR_MIP     = 12'h344;

    // Synchronous exception codes
    localparam logic [4:0] CAUSE_IAM   = 5'd0;
    localparam logic [4:0] CAUSE_II    = 5'd2;
    localparam logic [4:0] CAUSE_BP    = 5'd3;
    localparam logic [4:0] CAUSE_LAM   = 5'd4;
    localparam logic [4:0] CAUSE_SAM   = 5'd6;
    localparam logic [4:0] CAUSE_ECALL = 5'd11;

    // Interrupt codes; platform line i uses IRQ_BASE + i
    localparam logic [4:0] CAUSE_MSI = 5'd3;
    localparam logic [4:0] CAUSE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_MEI = 5'd11;
    localparam int         IRQ_BASE  = 16;

    // mstatus bit positions
    localparam int MSTATUS_MIE    = 3;
    localparam int MSTATUS_MPIE   = 7;
    localparam int MSTATUS_MPP_LO = 11;
    localparam int MSTATUS_MPP_HI = 12;

    // Trap sequencer states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ENTER = 2'd1,
        ST_RET   = 2'd2
    } trap_state_e;

endpackage
`default_nettype wire

// File: rtl/trap_ctrl_irq_pend.sv
`default_nettype none
// ============================================================================
// Module      : irq_pend
// Description : Per-line interrupt latching (edge or level), mip assembly
//               and fixed-priority selection of the winning interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_pend
    import trap_pkg::*;
#(
    parameter int                 XLEN      = 32,
    parameter int                 NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}}
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_meip,
    input  logic               i_mtip,
    input  logic               i_msip,
    input  logic [NUM_IRQ-1:0] i_irq,
    input  logic [NUM_IRQ-1:0] i_clr,
    input  logic [XLEN-1:0]    i_mie,
    input  logic               i_global_en,
    output logic               o_pend_valid,
    output logic [4:0]         o_pend_code,
    output logic [XLEN-1:0]    o_mip
);

    logic [NUM_IRQ-1:0] r_irq_prev;
    logic [NUM_IRQ-1:0] r_edge_latch;
    logic [NUM_IRQ-1:0] w_edge_set;
    logic [NUM_IRQ-1:0] w_line;
    logic [XLEN-1:0]    w_pend;

    // A rising edge in the same cycle as a clear keeps the latch set
    assign w_edge_set = i_irq & ~r_irq_prev & EDGE_MASK;
    assign w_line     = (r_edge_latch & EDGE_MASK) | (i_irq & ~EDGE_MASK);

    // Edge detector history and sticky latches for edge-triggered lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_irq_prev   <= '0;
            r_edge_latch <= '0;
        end else begin
            r_irq_prev   <= i_irq;
            r_edge_latch <= ((r_edge_latch & ~i_clr) | w_edge_set) & EDGE_MASK;
        end
    end

    // Assemble the architectural mip view
    always_comb begin
        o_mip                       = '0;
        o_mip[CAUSE_MEI]            = i_meip;
        o_mip[CAUSE_MTI]            = i_mtip;
        o_mip[CAUSE_MSI]            = i_msip;
        o_mip[IRQ_BASE +: NUM_IRQ]  = w_line;
    end

    assign w_pend       = o_mip & i_mie;
    assign o_pend_valid = i_global_en & (|w_pend);

    // Priority MEI > MSI > MTI > line 0 > line 1 ...; lowest priority assigned first
    always_comb begin
        o_pend_code = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_pend[IRQ_BASE + i]) begin
                o_pend_code = 5'(IRQ_BASE + i);
            end
        end
        if (w_pend[CAUSE_MTI]) o_pend_code = CAUSE_MTI;
        if (w_pend[CAUSE_MSI]) o_pend_code = CAUSE_MSI;
        if (w_pend[CAUSE_MEI]) o_pend_code = CAUSE_MEI;
    end

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : trap_ctrl
// Description : Machine trap CSRs, exception/interrupt arbitration and the
//               trap-entry / MRET sequencer beside write-back.
// Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl
    import trap_pkg::*;
#(
    parameter int                 XLEN      = 32,
    parameter int                 NUM_IRQ   = 4,
    parameter logic [NUM_IRQ-1:0] EDGE_MASK = {NUM_IRQ{1'b0}},
    parameter logic [XLEN-1:0]    MTVEC_RST = 32'h0000_0100
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               retire_valid_i,
    input  logic [XLEN-1:0]    retire_pc_i,
    input  logic               exc_valid_i,
    input  logic [3:0]         exc_cause_i,
    input  logic [XLEN-1:0]    exc_tval_i,
    input  logic               mret_i,
    input  logic               xint_meip_i,
    input  logic               xint_mtip_i,
    input  logic               xint_msip_i,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               csr_we_i,
    input  logic [11:0]        csr_addr_i,
    input  logic [XLEN-1:0]    csr_wdata_i,
    output logic [XLEN-1:0]    csr_rdata_o,
    output logic               csr_illegal_o,
    output logic               retire_ready_o,
    output logic               flush_o,
    output logic               redirect_valid_o,
    output logic [XLEN-1:0]    redirect_pc_o
);

    // Writable bits of mie: the three standard sources plus the platform lines
    localparam logic [XLEN-1:0] c_mie_mask = (XLEN'(1) << CAUSE_MEI) | (XLEN'(1) << CAUSE_MTI)
                                           | (XLEN'(1) << CAUSE_MSI)
                                           | (XLEN'({NUM_IRQ{1'b1}}) << IRQ_BASE);

    trap_state_e        r_state;
    trap_state_e        w_state_nxt;
    logic               r_st_mie;
    logic               r_st_mpie;
    logic [XLEN-1:0]    r_mie;
    logic [XLEN-1:0]    r_mtvec;
    logic [XLEN-1:0]    r_mepc;
    logic [XLEN-1:0]    r_mcause;
    logic [XLEN-1:0]    r_mtval;
    logic [XLEN-1:0]    w_mip;
    logic [XLEN-1:0]    w_mstatus;
    logic [XLEN-1:0]    w_tvec_base;
    logic [XLEN-1:0]    w_trap_target;
    logic               w_pend_valid;
    logic [4:0]         w_pend_code;
    logic               w_take_irq;
    logic               w_take_exc;
    logic               w_csr_wr;
    logic [NUM_IRQ-1:0] w_irq_clr;

    irq_pend #(
        .XLEN      (XLEN),
        .NUM_IRQ   (NUM_IRQ),
        .EDGE_MASK (EDGE_MASK)
    ) u_irq_pend (
        .clk          (clk_i),
        .rst_n        (rst_i),
        .i_meip       (xint_meip_i),
        .i_mtip       (xint_mtip_i),
        .i_msip       (xint_msip_i),
        .i_irq        (irq_i),
        .i_clr        (w_irq_clr),
        .i_mie        (r_mie),
        .i_global_en  (r_st_mie),
        .o_pend_valid (w_pend_valid),
        .o_pend_code  (w_pend_code),
        .o_mip        (w_mip)
    );

    // Writes only land while write-back is actually allowed to commit
    assign w_csr_wr = csr_we_i & retire_ready_o;

    // Vectored mode offsets only interrupts; exceptions always go to the base
    assign w_tvec_base   = {r_mtvec[XLEN-1:2], 2'b00};
    assign w_trap_target = (r_mtvec[1:0] == 2'b01 && r_mcause[XLEN-1])
                         ? w_tvec_base + (XLEN'(r_mcause[4:0]) << 2)
                         : w_tvec_base;

    // Latch clears: the interrupt being entered, or software writing 0 to mip
    always_comb begin
        w_irq_clr = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_irq_clr[i] = ((r_state == ST_ENTER) && r_mcause[XLEN-1]
                            && (r_mcause[4:0] == 5'(IRQ_BASE + i)))
                         || (w_csr_wr && (csr_addr_i == CSR_MIP) && !csr_wdata_i[IRQ_BASE + i]);
        end
    end

    // Sequencer state register
    always_ff @(posedge clk_i) begin
        if (!rst_i) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next state, retire handshake and redirect outputs
    always_comb begin
        w_state_nxt      = r_state;
        retire_ready_o   = 1'b0;
        flush_o          = 1'b0;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        w_take_irq       = 1'b0;
        w_take_exc       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                retire_ready_o = 1'b1;
                if (retire_valid_i) begin
                    if (w_pend_valid) begin
                        w_take_irq     = 1'b1;
                        retire_ready_o = 1'b0;
                        w_state_nxt    = ST_ENTER;
                    end else if (exc_valid_i) begin
                        w_take_exc     = 1'b1;
                        retire_ready_o = 1'b0;
                        w_state_nxt    = ST_ENTER;
                    end else if (mret_i) begin
                        w_state_nxt    = ST_RET;
                    end
                end
            end
            ST_ENTER: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = w_trap_target;
                w_state_nxt      = ST_IDLE;
            end
            ST_RET: begin
                flush_o          = 1'b1;
                redirect_valid_o = 1'b1;
                redirect_pc_o    = r_mepc;
                w_state_nxt      = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Trap CSR state: capture on trap detect, otherwise software writes
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_st_mie  <= 1'b0;
            r_st_mpie <= 1'b0;
            r_mie     <= '0;
            r_mtvec   <= MTVEC_RST;
            r_mepc    <= '0;
            r_mcause  <= '0;
            r_mtval   <= '0;
        end else begin
            if (w_take_irq) begin
                r_mepc   <= retire_pc_i;
                r_mcause <= {1'b1, {(XLEN-6){1'b0}}, w_pend_code};
                r_mtval  <= '0;
            end else if (w_take_exc) begin
                r_mepc   <= retire_pc_i;
                r_mcause <= {{(XLEN-4){1'b0}}, exc_cause_i};
                r_mtval  <= exc_tval_i;
            end else if (w_csr_wr) begin
                case (csr_addr_i)
                    CSR_MSTATUS: begin
                        r_st_mie  <= csr_wdata_i[MSTATUS_MIE];
                        r_st_mpie <= csr_wdata_i[MSTATUS_MPIE];
                    end
                    CSR_MIE:    r_mie    <= csr_wdata_i & c_mie_mask;
                    CSR_MTVEC:  r_mtvec  <= {csr_wdata_i[XLEN-1:2], 1'b0, csr_wdata_i[0]};
                    CSR_MEPC:   r_mepc   <= {csr_wdata_i[XLEN-1:2], 2'b00};
                    CSR_MCAUSE: r_mcause <= csr_wdata_i;
                    CSR_MTVAL:  r_mtval  <= csr_wdata_i;
                    default: ;
                endcase
            end
            if (r_state == ST_ENTER) begin
                r_st_mpie <= r_st_mie;
                r_st_mie  <= 1'b0;
            end else if (r_state == ST_RET) begin
                r_st_mie  <= r_st_mpie;
                r_st_mpie <= 1'b1;
            end
        end
    end

    // mstatus view: MPP is hardwired to machine mode
    always_comb begin
        w_mstatus                                = '0;
        w_mstatus[MSTATUS_MIE]                   = r_st_mie;
        w_mstatus[MSTATUS_MPIE]                  = r_st_mpie;
        w_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    end

    // Combinational CSR read port
    always_comb begin
        csr_rdata_o   = '0;
        csr_illegal_o = 1'b0;
        case (csr_addr_i)
            CSR_MSTATUS: csr_rdata_o = w_mstatus;
            CSR_MIE:     csr_rdata_o = r_mie;
            CSR_MTVEC:   csr_rdata_o = r_mtvec;
            CSR_MEPC:    csr_rdata_o = r_mepc;
            CSR_MCAUSE:  csr_rdata_o = r_mcause;
            CSR_MTVAL:   csr_rdata_o = r_mtval;
            CSR_MIP:     csr_rdata_o = w_mip;
            default:     csr_illegal_o = 1'b1;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_trap_ctrl
// Description : Directed self-checking bench for trap_ctrl (line 0 edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        retire_valid_i = 1'b0;
    logic [31:0] retire_pc_i = '0;
    logic        exc_valid_i = 1'b0;
    logic [3:0]  exc_cause_i = '0;
    logic [31:0] exc_tval_i = '0;
    logic        mret_i = 1'b0;
    logic        xint_meip_i = 1'b0;
    logic        xint_mtip_i = 1'b0;
    logic        xint_msip_i = 1'b0;
    logic [3:0]  irq_i = '0;
    logic        csr_we_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [31:0] csr_wdata_i = '0;
    logic [31:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        retire_ready_o;
    logic        flush_o;
    logic        redirect_valid_o;
    logic [31:0] redirect_pc_o;

    int total = 0;
    int bad   = 0;

    trap_ctrl #(
        .XLEN      (32),
        .NUM_IRQ   (4),
        .EDGE_MASK (4'b0001),
        .MTVEC_RST (32'h0000_0100)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .retire_valid_i   (retire_valid_i),
        .retire_pc_i      (retire_pc_i),
        .exc_valid_i      (exc_valid_i),
        .exc_cause_i      (exc_cause_i),
        .exc_tval_i       (exc_tval_i),
        .mret_i           (mret_i),
        .xint_meip_i      (xint_meip_i),
        .xint_mtip_i      (xint_mtip_i),
        .xint_msip_i      (xint_msip_i),
        .irq_i            (irq_i),
        .csr_we_i         (csr_we_i),
        .csr_addr_i       (csr_addr_i),
        .csr_wdata_i      (csr_wdata_i),
        .csr_rdata_o      (csr_rdata_o),
        .csr_illegal_o    (csr_illegal_o),
        .retire_ready_o   (retire_ready_o),
        .flush_o          (flush_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_pc_o    (redirect_pc_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic csr_rd(input logic [11:0] a, input logic [31:0] exp, input string tag);
        csr_addr_i = a;
        #1;
        check(tag, csr_rdata_o, exp);
    endtask

    task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
        csr_we_i    = 1'b1;
        csr_addr_i  = a;
        csr_wdata_i = d;
        tick();
        csr_we_i    = 1'b0;
    endtask

    task automatic retire(input logic [31:0] pc, input logic is_mret);
        retire_valid_i = 1'b1;
        retire_pc_i    = pc;
        mret_i         = is_mret;
    endtask

    task automatic retire_clr();
        retire_valid_i = 1'b0;
        mret_i         = 1'b0;
        exc_valid_i    = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        tick();
        tick();
        rst_i = 1'b1;
        check("rst_ready", 32'(retire_ready_o), 32'd1);
        check("rst_flush", 32'(flush_o), 32'd0);
        check("rst_redir_v", 32'(redirect_valid_o), 32'd0);
        check("rst_redir_pc", redirect_pc_o, 32'h0);
        csr_rd(12'h305, 32'h0000_0100, "rst_mtvec");
        csr_rd(12'h300, 32'h0000_1800, "rst_mstatus");
        csr_rd(12'h304, 32'h0, "rst_mie");
        csr_rd(12'h342, 32'h0, "rst_mcause");

        // ---------------- illegal CSR ----------------
        csr_rd(12'h7C0, 32'h0, "illegal_rdata");
        check("illegal_flag", 32'(csr_illegal_o), 32'd1);
        csr_rd(12'h344, 32'h0, "mip_read");
        check("mip_legal", 32'(csr_illegal_o), 32'd0);

        // ---------------- synchronous exception (CSR write same cycle dropped) ----------------
        tick();
        retire(32'h2000, 1'b0);
        exc_valid_i = 1'b1;
        exc_cause_i = 4'd2;
        exc_tval_i  = 32'hDEAD_BEEF;
        csr_we_i    = 1'b1;
        csr_addr_i  = 12'h343;
        csr_wdata_i = 32'h0000_1234;
        #1;
        check("exc_ready", 32'(retire_ready_o), 32'd0);
        tick();
        retire_clr();
        csr_we_i = 1'b0;
        check("exc_flush", 32'(flush_o), 32'd1);
        check("exc_redir_v", 32'(redirect_valid_o), 32'd1);
        check("exc_redir_pc", redirect_pc_o, 32'h0000_0100);
        check("exc_enter_ready", 32'(retire_ready_o), 32'd0);
        csr_rd(12'h341, 32'h0000_2000, "exc_mepc");
        csr_rd(12'h342, 32'h0000_0002, "exc_mcause");
        csr_rd(12'h343, 32'hDEAD_BEEF, "exc_mtval");
        tick();
        check("exc_back_ready", 32'(retire_ready_o), 32'd1);
        check("exc_back_flush", 32'(flush_o), 32'd0);

        // ---------------- vectored timer interrupt ----------------
        csr_wr(12'h305, 32'h0000_0403);
        csr_rd(12'h305, 32'h0000_0401, "mtvec_bit1_forced");
        csr_wr(12'h304, 32'h0000_0080);
        csr_wr(12'h300, 32'h0000_0008);
        xint_mtip_i = 1'b1;
        retire(32'h3000, 1'b0);
        #1;
        check("vec_ready", 32'(retire_ready_o), 32'd0);
        tick();
        retire_clr();
        xint_mtip_i = 1'b0;
        check("vec_redir_pc", redirect_pc_o, 32'h0000_041C);
        csr_rd(12'h342, 32'h8000_0007, "vec_mcause");
        csr_rd(12'h341, 32'h0000_3000, "vec_mepc");
        csr_rd(12'h343, 32'h0, "vec_mtval");
        tick();
        csr_rd(12'h300, 32'h0000_1880, "vec_mstatus");

        // ---------------- priority: MEI > MTI > line 0 ----------------
        csr_wr(12'h304, 32'h0001_0888);
        csr_wr(12'h300, 32'h0000_0008);
        xint_meip_i = 1'b1;
        xint_mtip_i = 1'b1;
        irq_i       = 4'b0001;
        tick();
        retire(32'h4000, 1'b0);
        tick();
        retire_clr();
        csr_rd(12'h342, 32'h8000_000B, "prio_mei");
        check("prio_mei_pc", redirect_pc_o, 32'h0000_042C);
        tick();
        xint_meip_i = 1'b0;
        retire(32'h4000, 1'b1);
        #1;
        check("mret_ready", 32'(retire_ready_o), 32'd1);
        tick();
        retire_clr();
        check("mret_redir_pc", redirect_pc_o, 32'h0000_4000);
        tick();
        retire(32'h4004, 1'b0);
        tick();
        retire_clr();
        csr_rd(12'h342, 32'h8000_0007, "prio_mti");
        tick();
        xint_mtip_i = 1'b0;
        retire(32'h4004, 1'b1);
        tick();
        retire_clr();
        tick();
        retire(32'h4008, 1'b0);
        tick();
        retire_clr();
        check("prio_line0_pc", redirect_pc_o, 32'h0000_0440);
        csr_rd(12'h342, 32'h8000_0010, "prio_line0");
        tick();
        csr_rd(12'h344, 32'h0, "enter_clears_latch");
        irq_i = 4'b0000;

        // ---------------- edge latch while MIE = 0 ----------------
        tick();
        irq_i = 4'b0001;
        tick();
        irq_i = 4'b0000;
        tick();
        tick();
        csr_rd(12'h344, 32'h0001_0000, "edge_held");
        csr_wr(12'h344, 32'h0001_0000);
        csr_rd(12'h344, 32'h0001_0000, "mip_write1_keeps");
        csr_wr(12'h344, 32'h0);
        csr_rd(12'h344, 32'h0, "mip_write0_clears");
        irq_i = 4'b0001;
        csr_wr(12'h344, 32'h0);
        csr_rd(12'h344, 32'h0001_0000, "set_beats_clear");
        irq_i = 4'b0000;
        csr_wr(12'h300, 32'h0000_0008);
        retire(32'h5000, 1'b0);
        #1;
        check("edge_trap_ready", 32'(retire_ready_o), 32'd0);
        tick();
        retire_clr();
        csr_rd(12'h342, 32'h8000_0010, "edge_trap_cause");
        tick();
        csr_rd(12'h344, 32'h0, "edge_trap_cleared");

        // ---------------- MRET ----------------
        csr_wr(12'h341, 32'h0000_2006);
        csr_rd(12'h341, 32'h0000_2004, "mepc_low_forced");
        csr_wr(12'h300, 32'h0000_0080);
        retire(32'h6000, 1'b1);
        tick();
        retire_clr();
        check("ret_flush", 32'(flush_o), 32'd1);
        check("ret_redir_pc", redirect_pc_o, 32'h0000_2004);
        tick();
        csr_rd(12'h300, 32'h0000_1888, "ret_mstatus");

        // ---------------- reset during RET ----------------
        csr_wr(12'h300, 32'h0000_0080);
        retire(32'h6004, 1'b1);
        tick();
        retire_clr();
        rst_i = 1'b0;
        tick();
        rst_i = 1'b1;
        check("rst_ret_redir_v", 32'(redirect_valid_o), 32'd0);
        check("rst_ret_ready", 32'(retire_ready_o), 32'd1);
        csr_rd(12'h300, 32'h0000_1800, "rst_ret_mstatus");
        csr_rd(12'h305, 32'h0000_0100, "rst_ret_mtvec");
        csr_rd(12'h341, 32'h0, "rst_ret_mepc");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
